// File: rtl/game2048_pkg.sv
//============================================================================
// game2048_pkg
// Shared types, state encoding, direction bits, endstatus codes and the
// (direction, line, element) -> cell index mapping for the 2048 board.
// Revision: 1.0
//============================================================================
`default_nettype none

package game2048_pkg;

  localparam int CELL_W   = 4;
  localparam int N_CELLS  = 16;
  localparam int LINE_LEN = 4;

  typedef logic [N_CELLS-1:0][CELL_W-1:0]  board_t;
  typedef logic [LINE_LEN-1:0][CELL_W-1:0] line_t;

  typedef enum logic [2:0] {
    INIT0  = 3'd0,
    INIT1  = 3'd1,
    SLIDE  = 3'd2,
    SPAWN  = 3'd3,
    COMMIT = 3'd4,
    CHECK  = 3'd5,
    IDLE   = 3'd6,
    OVER   = 3'd7
  } state_t;

  localparam int DIR_UP    = 3;
  localparam int DIR_DOWN  = 2;
  localparam int DIR_LEFT  = 1;
  localparam int DIR_RIGHT = 0;

  localparam logic [1:0] END_PLAYING = 2'b00;
  localparam logic [1:0] END_WON     = 2'b01;
  localparam logic [1:0] END_LOST    = 2'b10;

  // Cell index is row*4+col (0 = box1, top-left); element 0 sits nearest the move direction.
  function automatic logic [3:0] cell_index(input logic [1:0] dir,
                                            input logic [1:0] line,
                                            input logic [1:0] elem);
    logic [1:0] r;
    logic [1:0] c;
    r = line;
    c = elem;
    case (dir)
      2'(DIR_UP):    begin r = elem;         c = line;         end
      2'(DIR_DOWN):  begin r = 2'd3 - elem;  c = line;         end
      2'(DIR_LEFT):  begin r = line;         c = elem;         end
      default:       begin r = line;         c = 2'd3 - elem;  end
    endcase
    return {r, c};
  endfunction

endpackage

`default_nettype wire

// File: rtl/line_merge.sv
//============================================================================
// line_merge
// Combinational 2048 line slide: compact toward element 0, merge equal
// neighbours nearest-first (once per tile, saturating at 15), compact again.
// Revision: 1.0
//============================================================================
`default_nettype none

module line_merge
  import game2048_pkg::*;
(
  input  line_t cells_i,
  output line_t cells_o,
  output logic  changed_o
);

  function automatic line_t compact(input line_t l);
    line_t      r;
    logic [1:0] k;
    r = '0;
    k = '0;
    for (int i = 0; i < LINE_LEN; i++) begin
      if (l[i] != '0) begin
        r[k] = l[i];
        k    = k + 2'd1;
      end
    end
    return r;
  endfunction

  line_t packed_cells;
  line_t merged_cells;

  always_comb begin
    packed_cells = compact(cells_i);
    merged_cells = packed_cells;
    // A merged pair leaves a zero behind, so the next iteration cannot merge it again.
    for (int i = 0; i < LINE_LEN-1; i++) begin
      if (merged_cells[i] != '0 && merged_cells[i] == merged_cells[i+1]) begin
        merged_cells[i]   = (merged_cells[i] == 4'hF) ? 4'hF : merged_cells[i] + 4'd1;
        merged_cells[i+1] = '0;
      end
    end
    cells_o   = compact(merged_cells);
    changed_o = (cells_o != cells_i);
  end

endmodule

`default_nettype wire

// File: rtl/move_controller.sv
//============================================================================
// move_controller
// 2048 move sequencer: opening tiles, slide/merge one line per cycle,
// spawn, single-cycle commit strobe, win/lose detection.
// Optional build macro SPAWN_FOUR_EN: 1-in-16 spawns become a 4 tile.
// Revision: 1.0
//============================================================================
`default_nettype none

module move_controller
  import game2048_pkg::*;
#(
  parameter int          WIN_EXP   = 11,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic [3:0]  direction,
  input  logic [63:0] oldvalues,
  output logic        enable,
  output logic [63:0] newvalues,
  output logic        busy,
  output logic [1:0]  endstatus
);

  localparam logic [CELL_W-1:0] WIN_CELL = CELL_W'(WIN_EXP);

  state_t      state_q, state_d;
  board_t      board_q, board_d;
  logic [15:0] lfsr_q;
  logic [3:0]  dir_prev_q;
  logic [1:0]  line_q, line_d;
  logic [1:0]  dir_q, dir_d;
  logic        changed_q, changed_d;
  logic [3:0]  scan_idx_q, scan_idx_d;
  logic [3:0]  scan_cnt_q, scan_cnt_d;
  logic        init_q, init_d;
  logic [63:0] newvalues_q, newvalues_d;
  logic [1:0]  endstatus_q, endstatus_d;

  line_t       line_in, line_out;
  logic        line_chg;
  logic [3:0]  rise;
  logic [3:0]  spawn_idx;
  logic [3:0]  spawn_val;
  logic        any_win, any_empty, any_pair;

  line_merge u_line_merge (
    .cells_i   (line_in),
    .cells_o   (line_out),
    .changed_o (line_chg)
  );

  assign rise      = direction & ~dir_prev_q;
  assign spawn_idx = (scan_cnt_q == 4'd0) ? lfsr_q[3:0] : scan_idx_q;

`ifdef SPAWN_FOUR_EN
  assign spawn_val = (lfsr_q[7:4] == 4'd0) ? 4'd2 : 4'd1;
`else
  assign spawn_val = 4'd1;
`endif

  // Packed board slot [15-k] holds cell k, and 15-k == ~k for a 4-bit index.
  always_comb begin
    any_win   = 1'b0;
    any_empty = 1'b0;
    any_pair  = 1'b0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (board_q[~{2'(r), 2'(c)}] >= WIN_CELL) any_win = 1'b1;
        if (board_q[~{2'(r), 2'(c)}] == '0)       any_empty = 1'b1;
        if (c < 3 && board_q[~{2'(r), 2'(c)}] == board_q[~{2'(r), 2'(c+1)}]) any_pair = 1'b1;
        if (r < 3 && board_q[~{2'(r), 2'(c)}] == board_q[~{2'(r+1), 2'(c)}]) any_pair = 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    board_d     = board_q;
    line_d      = line_q;
    dir_d       = dir_q;
    changed_d   = changed_q;
    scan_idx_d  = scan_idx_q;
    scan_cnt_d  = scan_cnt_q;
    init_d      = init_q;
    newvalues_d = newvalues_q;
    endstatus_d = endstatus_q;
    line_in     = '0;
    for (int e = 0; e < LINE_LEN; e++) begin
      line_in[e] = board_q[~cell_index(dir_q, line_q, 2'(e))];
    end

    case (state_q)
      INIT0, INIT1, SPAWN: begin
        if (board_q[~spawn_idx] == '0) begin
          board_d[~spawn_idx] = spawn_val;
          scan_cnt_d          = '0;
          state_d             = COMMIT;
        end else if (scan_cnt_q == 4'd15) begin
          scan_cnt_d = '0;
          state_d    = COMMIT;
        end else begin
          scan_idx_d = spawn_idx + 4'd1;
          scan_cnt_d = scan_cnt_q + 4'd1;
        end
      end
      SLIDE: begin
        for (int e = 0; e < LINE_LEN; e++) begin
          board_d[~cell_index(dir_q, line_q, 2'(e))] = line_out[e];
        end
        changed_d = changed_q | line_chg;
        line_d    = line_q + 2'd1;
        if (line_q == 2'd3) begin
          state_d = (changed_q | line_chg) ? SPAWN : IDLE;
        end
      end
      COMMIT: state_d = CHECK;
      CHECK: begin
        if (any_win) begin
          endstatus_d = END_WON;
          state_d     = OVER;
        end else if (!any_empty && !any_pair) begin
          endstatus_d = END_LOST;
          state_d     = OVER;
        end else if (init_q) begin
          init_d  = 1'b0;
          state_d = INIT1;
        end else begin
          state_d = IDLE;
        end
      end
      IDLE: begin
        if (rise != 4'd0) begin
          board_d   = oldvalues;
          changed_d = 1'b0;
          line_d    = '0;
          state_d   = SLIDE;
          if      (rise[DIR_UP])   dir_d = 2'(DIR_UP);
          else if (rise[DIR_DOWN]) dir_d = 2'(DIR_DOWN);
          else if (rise[DIR_LEFT]) dir_d = 2'(DIR_LEFT);
          else                     dir_d = 2'(DIR_RIGHT);
        end
      end
      OVER: state_d = OVER;
      default: state_d = INIT0;
    endcase

    if (state_d == COMMIT && state_q != COMMIT) newvalues_d = board_d;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q     <= INIT0;
      board_q     <= '0;
      lfsr_q      <= LFSR_SEED;
      dir_prev_q  <= '0;
      line_q      <= '0;
      dir_q       <= '0;
      changed_q   <= 1'b0;
      scan_idx_q  <= '0;
      scan_cnt_q  <= '0;
      init_q      <= 1'b1;
      newvalues_q <= '0;
      endstatus_q <= END_PLAYING;
    end else begin
      state_q     <= state_d;
      board_q     <= board_d;
      lfsr_q      <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      dir_prev_q  <= direction;
      line_q      <= line_d;
      dir_q       <= dir_d;
      changed_q   <= changed_d;
      scan_idx_q  <= scan_idx_d;
      scan_cnt_q  <= scan_cnt_d;
      init_q      <= init_d;
      newvalues_q <= newvalues_d;
      endstatus_q <= endstatus_d;
    end
  end

  assign enable    = (state_q == COMMIT);
  assign busy      = (state_q != IDLE);
  assign newvalues = newvalues_q;
  assign endstatus = endstatus_q;

endmodule

`default_nettype wire

// File: tb/tb_move_controller.sv
//============================================================================
// tb_move_controller
// Directed, table-driven bench for move_controller with a box-array model.
// Revision: 1.0
//============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_move_controller;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic [3:0]  direction = 4'd0;
  logic [63:0] oldvalues;
  logic        enable;
  logic [63:0] newvalues;
  logic        busy;
  logic [1:0]  endstatus;

  logic [63:0] boxes = '0;
  logic [63:0] tb_board = '0;
  logic        tb_load = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  move_controller dut (
    .clock     (clock),
    .resetn    (resetn),
    .direction (direction),
    .oldvalues (oldvalues),
    .enable    (enable),
    .newvalues (newvalues),
    .busy      (busy),
    .endstatus (endstatus)
  );

  always #10 clock = ~clock;

  // Box register array: loads the whole board on enable; bench can preload it.
  always @(posedge clock) begin
    if (enable)       boxes <= newvalues;
    else if (tb_load) boxes <= tb_board;
  end
  assign oldvalues = boxes;

  typedef struct {
    logic [63:0] board;
    logic [3:0]  dir;
    logic [63:0] slid;
    bit          changed;
    logic [1:0]  status;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic int count_val(input logic [63:0] b, input logic [3:0] v);
    int n;
    n = 0;
    for (int k = 0; k < 16; k++) if (b[k*4 +: 4] == v) n++;
    return n;
  endfunction

  // Exactly one cell differs, and it went from empty to a 2-tile.
  function automatic bit spawn_ok(input logic [63:0] slid, input logic [63:0] got);
    int         diffs;
    bit         ok;
    logic [3:0] s;
    logic [3:0] g;
    diffs = 0;
    ok    = 1'b1;
    for (int k = 0; k < 16; k++) begin
      s = slid[k*4 +: 4];
      g = got[k*4 +: 4];
      if (s !== g) begin
        diffs++;
        if (s != 4'd0 || g != 4'd1) ok = 1'b0;
      end
    end
    return ok && (diffs == 1);
  endfunction

  task automatic do_reset();
    int en_cnt;
    bit done;
    tick();
    resetn    = 1'b0;
    direction = 4'd0;
    #1;
    chk("rst_enable",    64'(enable),    64'd0);
    chk("rst_newvalues", newvalues,      64'd0);
    chk("rst_endstatus", 64'(endstatus), 64'd0);
    chk("rst_busy",      64'(busy),      64'd1);
    tick();
    tick();
    resetn = 1'b1;
    en_cnt = 0;
    done   = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      tick();
      if (enable) en_cnt++;
      if (!busy) done = 1'b1;
    end
    chk("init_idle",    64'(done),                     64'd1);
    chk("init_enables", 64'(en_cnt),                   64'd2);
    chk("init_tiles",   64'(count_val(newvalues, 4'd1)), 64'd2);
    chk("init_empty",   64'(count_val(newvalues, 4'd0)), 64'd14);
    chk("init_status",  64'(endstatus),                64'd0);
  endtask

  task automatic load_board(input logic [63:0] b);
    tb_board = b;
    tb_load  = 1'b1;
    tick();
    tb_load  = 1'b0;
  endtask

  // Press a key (held 3 cycles) and watch 40 cycles.
  task automatic press(input logic [3:0] d, output int en_cnt, output int en_at, output int busy_run);
    bit still;
    en_cnt   = 0;
    en_at    = -1;
    busy_run = 0;
    still    = 1'b1;
    direction = d;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (i == 2) direction = 4'd0;
      if (enable) begin
        en_cnt++;
        if (en_at < 0) en_at = i;
      end
      if (still && busy) busy_run++;
      else still = 1'b0;
    end
  endtask

  initial begin
    int          en_cnt, en_at, busy_run;
    logic [63:0] nv_before;
    logic [1:0]  st_before;

    vecs[0] = '{64'h1122_0000_0000_0000, 4'b0010, 64'h2300_0000_0000_0000, 1'b1, 2'b00};
    vecs[1] = '{64'h1111_0000_0000_0000, 4'b0001, 64'h0022_0000_0000_0000, 1'b1, 2'b00};
    vecs[2] = '{64'h1200_3000_0000_0000, 4'b0010, 64'h1200_3000_0000_0000, 1'b0, 2'b00};
    vecs[3] = '{64'hA000_A000_0000_0000, 4'b1000, 64'hB000_0000_0000_0000, 1'b1, 2'b01};
    vecs[4] = '{64'h1212_0212_1212_2121, 4'b0010, 64'h1212_2120_1212_2121, 1'b1, 2'b10};
    vecs[5] = '{64'hFF00_0000_0000_0000, 4'b0010, 64'hF000_0000_0000_0000, 1'b1, 2'b01};
    vecs[6] = '{64'h0100_0000_0100_0300, 4'b0100, 64'h0000_0000_0200_0300, 1'b1, 2'b00};
    vecs[7] = '{64'h1122_0000_0000_0000, 4'b1010, 64'h1122_0000_0000_0000, 1'b0, 2'b00};

    for (int v = 0; v < 8; v++) begin
      do_reset();
      load_board(vecs[v].board);
      nv_before = newvalues;
      press(vecs[v].dir, en_cnt, en_at, busy_run);
      chk($sformatf("v%0d_enables", v), 64'(en_cnt), vecs[v].changed ? 64'd1 : 64'd0);
      if (vecs[v].changed) begin
        chk($sformatf("v%0d_board", v), 64'(spawn_ok(vecs[v].slid, newvalues)), 64'd1);
        chk($sformatf("v%0d_latency_ok", v), 64'(en_at >= 5 && en_at <= 20), 64'd1);
        chk($sformatf("v%0d_boxes", v), boxes, newvalues);
      end else begin
        chk($sformatf("v%0d_newvalues_held", v), newvalues, nv_before);
        chk($sformatf("v%0d_busy_cycles", v), 64'(busy_run), 64'd4);
      end
      chk($sformatf("v%0d_endstatus", v), 64'(endstatus), 64'(vecs[v].status));
      if (vecs[v].status != 2'b00) begin
        nv_before = newvalues;
        st_before = endstatus;
        press(4'b0001, en_cnt, en_at, busy_run);
        chk($sformatf("v%0d_over_enables", v), 64'(en_cnt), 64'd0);
        chk($sformatf("v%0d_over_status", v), 64'(endstatus), 64'(st_before));
        chk($sformatf("v%0d_over_busy", v), 64'(busy), 64'd1);
        chk($sformatf("v%0d_over_newvalues", v), newvalues, nv_before);
      end
    end

    // Reset during SLIDE aborts the move with no enable.
    do_reset();
    load_board(64'h1122_0000_0000_0000);
    direction = 4'b0010;
    en_cnt = 0;
    tick();
    if (enable) en_cnt++;
    tick();
    if (enable) en_cnt++;
    chk("abort_in_slide_busy", 64'(busy), 64'd1);
    resetn = 1'b0;
    #1;
    chk("abort_enable",    64'(enable),    64'd0);
    chk("abort_newvalues", newvalues,      64'd0);
    chk("abort_endstatus", 64'(endstatus), 64'd0);
    chk("abort_busy",      64'(busy),      64'd1);
    for (int i = 0; i < 30; i++) begin
      tick();
      if (enable) en_cnt++;
    end
    direction = 4'd0;
    chk("abort_no_enable", 64'(en_cnt), 64'd0);
    chk("abort_boxes",     boxes,       64'h1122_0000_0000_0000);
    resetn = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got no finish expected finish before 2ms");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
